// File: rtl/wb8_console_writer_if.sv
// Wishbone B4 8-bit write-only bus between the console writer and the VGA text slave.
interface wb8_console_writer_if;

  logic [12:0] ADR_O;
  logic [7:0]  DAT_O;
  logic        WE_O;
  logic        STB_O;
  logic        CYC_O;
  logic        ACK_I;

  modport master (
    output ADR_O,
    output DAT_O,
    output WE_O,
    output STB_O,
    output CYC_O,
    input  ACK_I
  );

  modport slave (
    input  ADR_O,
    input  DAT_O,
    input  WE_O,
    input  STB_O,
    input  CYC_O,
    output ACK_I
  );

endinterface

// File: rtl/wb8_console_writer.sv
// Console writer: turns a character/control byte stream into single Wishbone
// writes into a TEXT_COLS x TEXT_ROWS text RAM, tracking the cursor itself.
// Every cell write is BUS (held until ACK) followed by one GAP cycle with STB
// low, so the slave's lingering registered ACK is never mistaken for a new one.
module wb8_console_writer #(
  parameter logic [12:0] TEXT_BASE      = 13'h0000,
  parameter int unsigned TEXT_COLS      = 40,
  parameter int unsigned TEXT_ROWS      = 25,
  parameter bit          CLEAR_ON_RESET = 1'b1,
  parameter logic [7:0]  FILL_CHAR      = 8'h20
) (
  input  logic                 CLK_I,
  input  logic                 RST_N_I,
  input  logic [7:0]           I_char,
  input  logic                 I_char_valid,
  output logic                 O_char_ready,
  wb8_console_writer_if.master wb,
  output logic [5:0]           O_cursor_col,
  output logic [4:0]           O_cursor_row,
  output logic                 O_busy
);

  localparam int unsigned ADR_W = 13;
  localparam int unsigned COL_W = 6;
  localparam int unsigned ROW_W = 5;
  localparam int unsigned CELLS = TEXT_COLS * TEXT_ROWS;
  localparam int unsigned CLR_W = (CELLS > 1) ? $clog2(CELLS) : 1;

  localparam logic [COL_W-1:0] LAST_COL      = COL_W'(TEXT_COLS - 1);
  localparam logic [ROW_W-1:0] LAST_ROW      = ROW_W'(TEXT_ROWS - 1);
  localparam logic [CLR_W-1:0] LAST_CELL     = CLR_W'(CELLS - 1);
  localparam logic [CLR_W-1:0] LAST_ROW_CELL = CLR_W'(TEXT_COLS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BUS,
    S_GAP,
    S_CLR_ALL,
    S_CLR_ROW
  } state_e;

  // What the current bus write belongs to; GAP uses it to pick the next step.
  typedef enum logic [2:0] {
    OP_NONE,
    OP_CHAR,
    OP_WRAP,
    OP_ROW,
    OP_ALL
  } op_e;

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [CLR_W-1:0]   clr_q, clr_d;
  logic [ADR_W-1:0]   adr_q, adr_d;
  logic [7:0]         dat_q, dat_d;
  logic               stb_q;
  logic               ready_q;
  logic               busy_q;

  logic               accept_c;
  logic               is_print_c;
  logic [ROW_W-1:0]   next_row_c;

  // Linear cell address, wrapping modulo 2^13.
  function automatic logic [ADR_W-1:0] cell_addr(input logic [ROW_W-1:0] r,
                                                 input logic [COL_W-1:0] c);
    return TEXT_BASE + ADR_W'(r) * ADR_W'(TEXT_COLS) + ADR_W'(c);
  endfunction

  assign accept_c   = ready_q && I_char_valid;
  assign is_print_c = (I_char >= 8'h20) && (I_char != 8'h7F);
  assign next_row_c = (row_q == LAST_ROW) ? '0 : row_q + ROW_W'(1);

  // State, cursor, clear counter and registered bus/handshake outputs.
  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      state_q <= CLEAR_ON_RESET ? S_CLR_ALL : S_IDLE;
      op_q    <= OP_NONE;
      col_q   <= '0;
      row_q   <= '0;
      clr_q   <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      stb_q   <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      col_q   <= col_d;
      row_q   <= row_d;
      clr_q   <= clr_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      stb_q   <= (state_d == S_BUS);
      ready_q <= (state_d == S_IDLE);
      busy_q  <= (state_d != S_IDLE);
    end
  end

  // Next-state logic: byte decode, bus sequencing and clear stepping.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    col_d   = col_q;
    row_d   = row_q;
    clr_d   = clr_q;
    adr_d   = adr_q;
    dat_d   = dat_q;

    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          if (is_print_c) begin
            adr_d   = cell_addr(row_q, col_q);
            dat_d   = I_char;
            op_d    = OP_CHAR;
            state_d = S_BUS;
          end else begin
            case (I_char)
              8'h0A: begin
                col_d   = '0;
                row_d   = next_row_c;
                clr_d   = '0;
                state_d = S_CLR_ROW;
              end
              8'h0D: begin
                col_d   = '0;
                op_d    = OP_NONE;
                state_d = S_GAP;
              end
              8'h08: begin
                if (col_q != '0) begin
                  col_d   = col_q - COL_W'(1);
                  adr_d   = cell_addr(row_q, col_q - COL_W'(1));
                  dat_d   = FILL_CHAR;
                  op_d    = OP_NONE;
                  state_d = S_BUS;
                end
              end
              8'h0C: begin
                clr_d   = '0;
                state_d = S_CLR_ALL;
              end
              default: begin
              end
            endcase
          end
        end
      end

      S_CLR_ALL: begin
        adr_d   = TEXT_BASE + ADR_W'(clr_q);
        dat_d   = FILL_CHAR;
        op_d    = OP_ALL;
        state_d = S_BUS;
      end

      S_CLR_ROW: begin
        adr_d   = cell_addr(row_q, COL_W'(clr_q));
        dat_d   = FILL_CHAR;
        op_d    = OP_ROW;
        state_d = S_BUS;
      end

      S_BUS: begin
        if (wb.ACK_I) begin
          state_d = S_GAP;
          if (op_q == OP_CHAR) begin
            if (col_q == LAST_COL) begin
              col_d = '0;
              row_d = next_row_c;
              op_d  = OP_WRAP;
            end else begin
              col_d = col_q + COL_W'(1);
            end
          end
        end
      end

      S_GAP: begin
        case (op_q)
          OP_WRAP: begin
            clr_d   = '0;
            state_d = S_CLR_ROW;
          end
          OP_ROW: begin
            if (clr_q == LAST_ROW_CELL) begin
              clr_d   = '0;
              state_d = S_IDLE;
            end else begin
              clr_d   = clr_q + CLR_W'(1);
              state_d = S_CLR_ROW;
            end
          end
          OP_ALL: begin
            if (clr_q == LAST_CELL) begin
              clr_d   = '0;
              col_d   = '0;
              row_d   = '0;
              state_d = S_IDLE;
            end else begin
              clr_d   = clr_q + CLR_W'(1);
              state_d = S_CLR_ALL;
            end
          end
          default: state_d = S_IDLE;
        endcase
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign wb.ADR_O     = adr_q;
  assign wb.DAT_O     = dat_q;
  assign wb.STB_O     = stb_q;
  assign wb.CYC_O     = stb_q;
  assign wb.WE_O      = stb_q;
  assign O_char_ready = ready_q;
  assign O_busy       = busy_q;
  assign O_cursor_col = col_q;
  assign O_cursor_row = row_q;

endmodule

// File: tb/tb_wb8_console_writer.sv
// Directed bench for wb8_console_writer with a registered-ACK slave model.
module tb_wb8_console_writer;

  localparam int unsigned BUDGET = 6000;

  typedef struct packed {
    logic [12:0] adr;
    logic [7:0]  dat;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] ch;
  logic       ch_valid;
  logic       ch_ready;
  logic [5:0] ccol;
  logic [4:0] crow;
  logic       busy;

  int vectors    = 0;
  int miscompares = 0;

  int unsigned stretch = 0;
  int unsigned wait_cnt;
  int          stb_cycles = 0;
  int          proto_err  = 0;
  logic        prev_write;
  logic        prev_stb;
  logic [12:0] hold_adr;
  logic [7:0]  hold_dat;
  wr_t         wr_q[$];

  always #5 clk = ~clk;

  wb8_console_writer_if bus();

  wb8_console_writer #(
    .TEXT_BASE(13'h0000),
    .TEXT_COLS(40),
    .TEXT_ROWS(25),
    .CLEAR_ON_RESET(1'b1),
    .FILL_CHAR(8'h20)
  ) dut (
    .CLK_I(clk),
    .RST_N_I(rst_n),
    .I_char(ch),
    .I_char_valid(ch_valid),
    .O_char_ready(ch_ready),
    .wb(bus.master),
    .O_cursor_col(ccol),
    .O_cursor_row(crow),
    .O_busy(busy)
  );

  // Slave: registered ACK after 'stretch' extra cycles, lingering one cycle after STB falls.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.ACK_I <= 1'b0;
      wait_cnt  <= 0;
    end else if (bus.STB_O && !bus.ACK_I) begin
      if (wait_cnt >= stretch) begin
        bus.ACK_I <= 1'b1;
        wait_cnt  <= 0;
      end else begin
        wait_cnt <= wait_cnt + 1;
      end
    end else begin
      bus.ACK_I <= bus.STB_O;
    end
  end

  // Bus monitor: logs completed writes and flags protocol breaches.
  always @(negedge clk) begin
    int e;
    e = 0;
    if (rst_n) begin
      if (bus.CYC_O !== bus.STB_O) e++;
      if (bus.STB_O && bus.WE_O !== 1'b1) e++;
      if (busy !== !ch_ready) e++;
      if (bus.STB_O && prev_stb && (bus.ADR_O !== hold_adr || bus.DAT_O !== hold_dat)) e++;
      if (prev_write && bus.STB_O) e++;
      if (bus.STB_O) stb_cycles <= stb_cycles + 1;
      if (bus.STB_O && bus.ACK_I) wr_q.push_back('{bus.ADR_O, bus.DAT_O});
      proto_err  <= proto_err + e;
      prev_write <= bus.STB_O && bus.ACK_I;
      prev_stb   <= bus.STB_O;
      hold_adr   <= bus.ADR_O;
      hold_dat   <= bus.DAT_O;
    end else begin
      prev_write <= 1'b0;
      prev_stb   <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic wr_t wr_at(input int i);
    if (i < wr_q.size()) return wr_q[i];
    return '1;
  endfunction

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ch_ready && n < BUDGET);
    if (!ch_ready) check({tag, "_timeout"}, 32'(ch_ready), 32'd1);
  endtask

  task automatic send(input logic [7:0] b);
    ch       = b;
    ch_valid = 1'b1;
    @(posedge clk);
    #1 ch_valid = 1'b0;
    wait_ready("send");
  endtask

  task automatic send_n(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) send(b);
  endtask

  task automatic check_run(input string tag, input int from, input int n,
                           input int adr0, input logic [7:0] d);
    int bad;
    wr_t w;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      w = wr_at(from + i);
      if (w.adr !== 13'(adr0 + i) || w.dat !== d) bad++;
    end
    check(tag, 32'(bad), 32'd0);
  endtask

  task automatic check_cursor(input string tag, input int col, input int row);
    check({tag, "_col"}, 32'(ccol), 32'(col));
    check({tag, "_row"}, 32'(crow), 32'(row));
  endtask

  initial begin
    int base;
    int s0;
    rst_n    = 1'b1;
    ch       = 8'h00;
    ch_valid = 1'b0;
    #2 rst_n = 1'b0;

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_stb", 32'(bus.STB_O), 32'd0);
    check("rst_cyc", 32'(bus.CYC_O), 32'd0);
    check("rst_adr", 32'(bus.ADR_O), 32'd0);
    check("rst_dat", 32'(bus.DAT_O), 32'd0);
    check("rst_ready", 32'(ch_ready), 32'd0);
    check_cursor("rst", 0, 0);

    // Power-up clear of the whole screen.
    base  = wr_q.size();
    rst_n = 1'b1;
    wait_ready("clr_all");
    check("clr_all_count", 32'(wr_q.size() - base), 32'd1000);
    check_run("clr_all_cells", base, 1000, 0, 8'h20);
    check("clr_all_ready", 32'(ch_ready), 32'd1);
    check_cursor("clr_all", 0, 0);

    // Two printables.
    base = wr_q.size();
    send(8'h41);
    send(8'h42);
    check("ab_count", 32'(wr_q.size() - base), 32'd2);
    check("ab_w0", 32'(wr_at(base)), 32'({13'd0, 8'h41}));
    check("ab_w1", 32'(wr_at(base + 1)), 32'({13'd1, 8'h42}));
    check_cursor("ab", 2, 0);

    // Column wrap at (39,3).
    send_n(8'h0A, 3);
    send_n(8'h78, 39);
    check_cursor("pre_wrap", 39, 3);
    base = wr_q.size();
    send(8'h5A);
    check("wrap_count", 32'(wr_q.size() - base), 32'd41);
    check("wrap_char", 32'(wr_at(base)), 32'({13'd159, 8'h5A}));
    check_run("wrap_row_clr", base + 1, 40, 160, 8'h20);
    check_cursor("wrap", 0, 4);

    // LF on the last row wraps to row 0 and clears it.
    send_n(8'h0A, 20);
    send_n(8'h79, 5);
    check_cursor("pre_lf", 5, 24);
    base = wr_q.size();
    send(8'h0A);
    check("lf_wrap_count", 32'(wr_q.size() - base), 32'd40);
    check_run("lf_wrap_clr", base, 40, 0, 8'h20);
    check_cursor("lf_wrap", 0, 0);

    // CR: no bus activity.
    send_n(8'h0A, 2);
    send_n(8'h7A, 7);
    check_cursor("pre_cr", 7, 2);
    s0 = stb_cycles;
    send(8'h0D);
    check("cr_stb", 32'(stb_cycles - s0), 32'd0);
    check_cursor("cr", 0, 2);

    // Form feed clears everything.
    base = wr_q.size();
    send(8'h0C);
    check("ff_count", 32'(wr_q.size() - base), 32'd1000);
    check_run("ff_cells", base, 1000, 0, 8'h20);
    check_cursor("ff", 0, 0);

    // Backspace and discarded codes.
    send(8'h0A);
    send_n(8'h71, 3);
    check_cursor("pre_bs", 3, 1);
    base = wr_q.size();
    send(8'h08);
    check("bs_count", 32'(wr_q.size() - base), 32'd1);
    check("bs_write", 32'(wr_at(base)), 32'({13'd42, 8'h20}));
    check_cursor("bs", 2, 1);
    send_n(8'h08, 2);
    s0 = stb_cycles;
    send(8'h08);
    check("bs0_stb", 32'(stb_cycles - s0), 32'd0);
    check_cursor("bs0", 0, 1);
    send(8'h07);
    send(8'h7F);
    check("discard_stb", 32'(stb_cycles - s0), 32'd0);
    check_cursor("discard", 0, 1);
    base = wr_q.size();
    send(8'hC5);
    check("hi_write", 32'(wr_at(base)), 32'({13'd40, 8'hC5}));
    check_cursor("hi", 1, 1);

    // Reset during a stretched bus cycle.
    stretch  = 5;
    base     = wr_q.size();
    ch       = 8'h41;
    ch_valid = 1'b1;
    @(posedge clk);
    #1 ch_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_bus_stb", 32'(bus.STB_O), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_stb", 32'(bus.STB_O), 32'd0);
    check("async_cyc", 32'(bus.CYC_O), 32'd0);
    check("async_ready", 32'(ch_ready), 32'd0);
    check("aborted_write", 32'(wr_q.size() - base), 32'd0);
    stretch = 0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready("re_clr");
    check("re_clr_count", 32'(wr_q.size() - base), 32'd1000);
    check_run("re_clr_cells", base, 1000, 0, 8'h20);
    check_cursor("re_clr", 0, 0);

    check("protocol", 32'(proto_err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
